wb_mem_arbiter: RTL
===================

# wb_mem_arbiter

Two-master, one-slave Wishbone arbiter that shares the single external memory port between the host loader (port 0) and the Levenshtein search engine (port 1). Grants are round-robin per bus cycle (`cyc` tenure), and routing is combinational once a grant is held. A per-transfer timeout turns a silent slave into an `err`. A port that has seen `err`/`rty` is quarantined until it drops `cyc`, so a master that stops its FSM with `cyc` still high cannot lock the memory.

## Interface
- `ADDR_WIDTH`, 24, address width on all three ports.
- `TIMEOUT_CYCLES`, 255, wait cycles before a forced `err`. 0 disables the timeout.
- `TIMEOUT_WIDTH`, 8, width of the timeout counter. Must satisfy ≥ $clog2(TIMEOUT_CYCLES+1).
- `clk_i  in  1`  Clock. One clock domain for the whole block.
- `rst_i  in  1`  Reset. Synchronous and active-high.
- `wbs0_cyc_i, wbs0_stb_i, wbs0_we_i  in  1 each`  Port 0 (host) request.
- `wbs0_adr_i  in  ADDR_WIDTH`, `wbs0_dat_i  in  8`  Port 0 address and write data.
- `wbs0_ack_o, wbs0_err_o, wbs0_rty_o  out  1 each`, `wbs0_dat_o  out  8`  Port 0 response.
- `wbs1_*`  Identical set for port 1 (engine).
- `wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each`, `wbm_adr_o  out  ADDR_WIDTH`, `wbm_dat_o  out  8`  Downstream request to the memory.
- `wbm_ack_i, wbm_err_i, wbm_rty_i  in  1 each`, `wbm_dat_i  in  8`  Downstream response.
- `grant_o  out  2`  One-hot current owner; 00 means idle.

## Operation
- **States:** IDLE, OWN0, OWN1. `grant_o` mirrors the state.
- **Request definition:** port p requests when `wbsp_cyc_i` is 1 and `stale[p]` is 0.
- **Arbitration in IDLE:** at the clock edge, grant the single requester. If both request, grant the port selected by `rr_next`.
- **Round-robin pointer:** on every grant, `rr_next` is set to the other port. Reset value selects port 0.
- **Routing while OWNp:**
  - `wbm_*` outputs follow port p's inputs combinationally.
  - Port p's `ack`/`err`/`rty`/`dat` outputs follow `wbm_*` inputs combinationally.
  - The non-owner sees `ack`/`err`/`rty`=0 and `dat`=0.
- **Idle outputs:** in IDLE, all `wbm_*` outputs are 0.
- **Release:** the grant holds for as long as owner `cyc` stays high, which covers multiple `stb` beats.
  - The edge that samples owner `cyc`=0 releases the grant and re-arbitrates at that same edge.
  - A zero-gap hand-over to the other port is therefore possible.
- **Quarantine:** `stale[p]` sets on any cycle in which port p sees `err_o` or `rty_o`.
  - When it sets, the state goes to IDLE at that edge.
  - `stale[p]` clears on the edge that samples `wbsp_cyc_i`=0.
- **Timeout counter:**
  - Cleared on grant and on any downstream `ack`/`err`/`rty`.
  - Increments each owned cycle in which `wbm_stb_o`=1 and no response arrives. It saturates and never wraps.
- **Timeout firing:** on the cycle the counter equals `TIMEOUT_CYCLES` with no response:
  - The owner gets `err`=1 for that cycle only.
  - `wbm_cyc_o` and `wbm_stb_o` are forced to 0 that cycle.
  - `stale` sets and the grant releases.
- **Simultaneous events:**
  - A downstream `ack` in the timeout cycle wins: the owner gets the ack, no `err`, and the counter clears.
  - A downstream `err` or `rty` is passed through unchanged and quarantines the owner.
  - A reset asserted mid-transfer aborts it: the next cycle has `wbm_cyc_o`=0, and no response is synthesised for the master.

## Timing
- **Reset values:**
  - State IDLE, `grant_o`=00.
  - All `wbm_*` outputs 0.
  - All `wbsp_ack`/`err`/`rty`/`dat` outputs 0.
  - `stale`=00, counter 0, `rr_next`=port 0.
- **Grant latency:** a request seen in IDLE at cycle N is granted at the edge ending N. `wbm_cyc_o` is 1 in cycle N+1.
- **Data path latency:** once granted, request and response paths have zero cycles of latency.
- **Hand-over:** the owner drops `cyc` in cycle K. If the other port requests in K, it owns the bus in K+1.
- **Timeout example:** with `TIMEOUT_CYCLES`=4, `stb` first owned in cycle 1 with no response gives counter values 0..3 in cycles 1-4. `err` is asserted in cycle 5.

## Structure
- Constants and types go in the shared package `levenshtein_pkg`: the state enum (IDLE/OWN0/OWN1) and the port-index localparams.
- One sub-module, `wb_timeout_counter`, is natural. It takes clear, enable and limit, and outputs `expired` and `count`.
- Everything else stays flat in `wb_mem_arbiter`.

## Test plan
- **Single master:** port 1 reads `adr` 0x800000 with ack after 2 cycles. Expect `grant_o`=10 one cycle after `cyc`, `dat` passed through, and no activity on port 0.
- **Contention:** both ports raise `cyc` in the same cycle after reset. Expect port 0 granted first. Port 0 drops `cyc` with port 1 still waiting; expect port 1 owning the bus the next cycle. Both then re-request; expect port 0.
- **Zero-gap hand-over:** port 1 toggles `cyc` low for one cycle between beats while port 0 waits. Expect port 0 granted in that gap and port 1 waiting until port 0 finishes.
- **Timeout:** `TIMEOUT_CYCLES`=4 and the slave never responds. Expect `wbs0_err_o` pulse in the 5th owned cycle with `wbm_cyc_o`=0 in that cycle. Port 0 keeps `cyc`=1; expect it ignored while port 1 is served. Port 0 drops `cyc` for one cycle; expect it regranted afterwards.
- **Ack at the deadline:** slave acks exactly in the timeout cycle. Expect `ack` delivered, no `err`, and no quarantine.
- **Reset mid-transfer:** assert `rst_i` during an owned wait. Expect all outputs 0 and `grant_o`=00 the next cycle.

Source files
------------

// File: rtl/levenshtein_pkg.sv
// Shared types and constants for the Levenshtein accelerator memory subsystem.
// The arbiter state doubles as the one-hot grant vector.
package levenshtein_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  localparam int PORT_HOST   = 0;
  localparam int PORT_ENGINE = 1;
  localparam int NUM_PORTS   = 2;

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-state counter for a single Wishbone transfer; flags when the count
// reaches the programmed limit (a limit of zero never expires).
module wb_timeout_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_reg <= '0;
    end else if (en_i) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count_o   = count_reg;
  assign expired_o = (limit_i != '0) && (count_reg == limit_i);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the external memory,
// with a per-transfer timeout and quarantine of masters that saw err/rty.
module wb_mem_arbiter
  import levenshtein_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbs0_cyc_i,
  input  logic                  wbs0_stb_i,
  input  logic                  wbs0_we_i,
  input  logic [ADDR_WIDTH-1:0] wbs0_adr_i,
  input  logic [7:0]            wbs0_dat_i,
  output logic                  wbs0_ack_o,
  output logic                  wbs0_err_o,
  output logic                  wbs0_rty_o,
  output logic [7:0]            wbs0_dat_o,
  input  logic                  wbs1_cyc_i,
  input  logic                  wbs1_stb_i,
  input  logic                  wbs1_we_i,
  input  logic [ADDR_WIDTH-1:0] wbs1_adr_i,
  input  logic [7:0]            wbs1_dat_i,
  output logic                  wbs1_ack_o,
  output logic                  wbs1_err_o,
  output logic                  wbs1_rty_o,
  output logic [7:0]            wbs1_dat_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [ADDR_WIDTH-1:0] wbm_adr_o,
  output logic [7:0]            wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i,
  input  logic                  wbm_rty_i,
  input  logic [7:0]            wbm_dat_i,
  output logic [1:0]            grant_o
);

  arb_state_t             state_reg;
  logic [NUM_PORTS-1:0]   stale_reg, stale_next;
  logic                   rr_ptr_reg;
  logic [NUM_PORTS-1:0]   cyc_v, own_v, req_v, ack_v, err_v, rty_v;
  logic                   owned, own_sel, own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0]  own_adr;
  logic [7:0]             own_dat;
  logic                   resp, quarantine, arb_valid, arb_port;
  logic                   tmo_clr, tmo_en, tmo_expired, tmo_fire;
  logic [TIMEOUT_WIDTH-1:0] tmo_count;

  assign cyc_v = {wbs1_cyc_i, wbs0_cyc_i};
  assign own_v = state_reg;
  assign owned = |own_v;
  assign own_sel = own_v[PORT_ENGINE];

  assign own_cyc = own_sel ? wbs1_cyc_i : wbs0_cyc_i;
  assign own_stb = own_sel ? wbs1_stb_i : wbs0_stb_i;
  assign own_we  = own_sel ? wbs1_we_i  : wbs0_we_i;
  assign own_adr = own_sel ? wbs1_adr_i : wbs0_adr_i;
  assign own_dat = own_sel ? wbs1_dat_i : wbs0_dat_i;

  assign resp = wbm_ack_i | wbm_err_i | wbm_rty_i;

  // The raw owner strobe drives the counter so the forced-low wbm_stb_o of the
  // firing cycle cannot feed back into its own enable.
  assign tmo_clr  = ~owned | resp;
  assign tmo_en   = owned & own_stb & ~resp & (tmo_count != '1);
  assign tmo_fire = owned & own_cyc & own_stb & ~resp & tmo_expired;

  wb_timeout_counter #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .limit_i   (TIMEOUT_WIDTH'(TIMEOUT_CYCLES)),
    .expired_o (tmo_expired),
    .count_o   (tmo_count)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign ack_v[gi] = own_v[gi] & wbm_ack_i;
      assign err_v[gi] = own_v[gi] & (wbm_err_i | tmo_fire);
      assign rty_v[gi] = own_v[gi] & wbm_rty_i;
      assign req_v[gi] = cyc_v[gi] & ~stale_reg[gi];
      assign stale_next[gi] = (err_v[gi] | rty_v[gi]) ? 1'b1 :
                              (cyc_v[gi] ? stale_reg[gi] : 1'b0);
    end
  endgenerate

  assign wbm_cyc_o = owned & own_cyc & ~tmo_fire;
  assign wbm_stb_o = owned & own_stb & ~tmo_fire;
  assign wbm_we_o  = owned & own_we;
  assign wbm_adr_o = owned ? own_adr : '0;
  assign wbm_dat_o = owned ? own_dat : '0;

  assign wbs0_ack_o = ack_v[PORT_HOST];
  assign wbs0_err_o = err_v[PORT_HOST];
  assign wbs0_rty_o = rty_v[PORT_HOST];
  assign wbs0_dat_o = own_v[PORT_HOST] ? wbm_dat_i : '0;
  assign wbs1_ack_o = ack_v[PORT_ENGINE];
  assign wbs1_err_o = err_v[PORT_ENGINE];
  assign wbs1_rty_o = rty_v[PORT_ENGINE];
  assign wbs1_dat_o = own_v[PORT_ENGINE] ? wbm_dat_i : '0;

  assign quarantine = |(err_v | rty_v);
  assign arb_valid  = |req_v;
  assign arb_port   = (req_v == 2'b11) ? rr_ptr_reg : req_v[PORT_ENGINE];

  // A released owner has cyc low, so its request bit is already clear and the
  // same arbitration covers both IDLE and the zero-gap hand-over.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= IDLE;
      stale_reg  <= '0;
      rr_ptr_reg <= 1'(PORT_HOST);
    end else begin
      stale_reg <= stale_next;
      if (quarantine) begin
        state_reg <= IDLE;
      end else if (state_reg == IDLE || !own_cyc) begin
        if (arb_valid) begin
          state_reg  <= arb_port ? OWN1 : OWN0;
          rr_ptr_reg <= ~arb_port;
        end else begin
          state_reg <= IDLE;
        end
      end
    end
  end

  assign grant_o = state_reg;

endmodule
